// File: rtl/serial_add_sched.sv
// Round-robin scheduler that shares one external serial adder between two requesters.
// It latches the winner's operands, drives the datapath, and returns the sum with a done pulse.
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             busy,
  output logic             dp_clear,
  output logic             dp_load,
  output logic             dp_enable,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic             dp_sum_bit,
  input  logic             dp_cout_bit,
  output logic [2:0]       dbg_state
);
  // Handshake: a requester holds reqN high until it sees its one-cycle doneN pulse;
  // a reqN still high in IDLE after that pulse counts as a fresh request.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] dp_a_q, dp_a_d;
  logic [WIDTH-1:0] dp_b_q, dp_b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             winner;
  logic [WIDTH-1:0] sh_next;

  // On a tie the requester that was not served last wins.
  assign winner  = (req0 && req1) ? ~last_grant_q : req1;
  assign sh_next = {dp_sum_bit, sh_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      sh_q         <= '0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      sh_q         <= sh_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req0 || req1) state_d = S_CLEAR;
      S_CLEAR: state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == LAST_CNT) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    sh_d         = sh_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = winner;
          dp_a_d  = winner ? a1 : a0;
          dp_b_d  = winner ? b1 : b0;
        end
      end
      S_LOAD: cnt_d = '0;
      S_SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d  = sh_next;
          cout_d = dp_cout_bit;
        end
      end
      S_DONE: last_grant_d = owner_q;
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    dp_clear  = (state_q == S_CLEAR);
    dp_load   = (state_q == S_LOAD);
    dp_enable = (state_q == S_SHIFT);
    done0     = (state_q == S_DONE) && !owner_q;
    done1     = (state_q == S_DONE) && owner_q;
  end

  assign sum_out   = sum_q;
  assign cout      = cout_q;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched with a behavioural serial adder and a result scoreboard.
module tb_serial_add_sched;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         done0, done1, cout, busy, dp_clear, dp_load, dp_enable;
  logic [W-1:0] sum_out, dp_a, dp_b;
  logic         dp_sum_bit, dp_cout_bit;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  serial_add_sched #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .sum_out(sum_out), .cout(cout), .busy(busy),
    .dp_clear(dp_clear), .dp_load(dp_load), .dp_enable(dp_enable),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sum_bit(dp_sum_bit), .dp_cout_bit(dp_cout_bit),
    .dbg_state(dbg_state)
  );

  // Behavioural serial adder: operand shift registers plus a carry flop.
  logic [W-1:0] m_a, m_b;
  logic         m_c;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_a <= '0; m_b <= '0; m_c <= 1'b0;
    end else if (dp_clear) begin
      m_a <= '0; m_b <= '0; m_c <= 1'b0;
    end else if (dp_load) begin
      m_a <= dp_a; m_b <= dp_b;
    end else if (dp_enable) begin
      m_a <= m_a >> 1; m_b <= m_b >> 1; m_c <= dp_cout_bit;
    end
  end
  assign dp_sum_bit  = m_a[0] ^ m_b[0] ^ m_c;
  assign dp_cout_bit = (m_a[0] & m_b[0]) | (m_c & (m_a[0] ^ m_b[0]));

  // Scoreboard entry: {who, cout, sum}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] e;
  int total = 0, bad = 0;
  int cyc = 0, done_cyc = 0, accept_cyc = 0;
  int n_en = 0, n_clr = 0, n_ld = 0, n_idle = 0;
  logic got_done = 1'b0;
  int d_first, d_prev, d_now;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic who, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    exp_q.push_back({who, s[W], s[W-1:0]});
  endtask

  // One clock: advance past the rising edge, then sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    n_en  += int'(dp_enable);
    n_clr += int'(dp_clear);
    n_ld  += int'(dp_load);
    n_idle += int'(!busy);
    if (done0 || done1) begin
      got_done = 1'b1;
      done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'({done1, done0}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_who", 32'({done1, done0}), e[W+1] ? 32'd2 : 32'd1);
        check("sum_out", 32'(sum_out), 32'(e[W-1:0]));
        check("cout", 32'(cout), 32'(e[W]));
      end
    end
  endtask

  task automatic wait_done();
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) tick();
    check("done_timeout", 32'(got_done), 32'd1);
  endtask

  task automatic reset_counts();
    n_en = 0; n_clr = 0; n_ld = 0; n_idle = 0;
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dones", 32'({done0, done1}), 32'd0);
    check("rst_dp_ctrl", 32'({dp_clear, dp_load, dp_enable}), 32'd0);
    check("rst_dp_ops", 32'({dp_a, dp_b}), 32'd0);
    check("rst_result", 32'({cout, sum_out}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single request from requester 0: latency and datapath control counts
    a0 = 8'h35; b0 = 8'h4A; req0 = 1'b1;
    push_exp(1'b0, 8'h35, 8'h4A);
    accept_cyc = cyc;
    reset_counts();
    wait_done();
    req0 = 1'b0;
    check("latency0", 32'(done_cyc - accept_cyc), 32'(W + 3));
    check("enable_cycles", 32'(n_en), 32'(W));
    check("clear_cycles", 32'(n_clr), 32'd1);
    check("load_cycles", 32'(n_ld), 32'd1);
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Requester 1 with carry-out
    a1 = 8'hFF; b1 = 8'h01; req1 = 1'b1;
    push_exp(1'b1, 8'hFF, 8'h01);
    wait_done();
    req1 = 1'b0;
    tick();

    // Tie straight after reset: requester 0 first, requester 1 twelve cycles later
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    a0 = 8'h10; b0 = 8'h20; a1 = 8'hF0; b1 = 8'h20;
    req0 = 1'b1; req1 = 1'b1;
    push_exp(1'b0, 8'h10, 8'h20);
    push_exp(1'b1, 8'hF0, 8'h20);
    wait_done();
    req0 = 1'b0;
    d_first = done_cyc;
    wait_done();
    req1 = 1'b0;
    check("tie_gap", 32'(done_cyc - d_first), 32'(W + 4));
    tick();

    // Both held for four operations: grants alternate, one idle cycle between
    a0 = W'($urandom_range(0, 255)); b0 = W'($urandom_range(0, 255));
    a1 = W'($urandom_range(0, 255)); b1 = W'($urandom_range(0, 255));
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(1'b0, a0, b0);
      else push_exp(1'b1, a1, b1);
    end
    wait_done();
    d_prev = done_cyc;
    reset_counts();
    for (int k = 1; k < 4; k++) begin
      wait_done();
      d_now = done_cyc;
      check("rr_gap", 32'(d_now - d_prev), 32'(W + 4));
      d_prev = d_now;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_idle_cycles", 32'(n_idle), 32'd3);
    tick();

    // Reset asserted during the fourth SHIFT cycle discards the operation
    a0 = 8'h55; b0 = 8'h66; req0 = 1'b1;
    repeat (6) tick();
    check("mid_shift_enable", 32'(dp_enable), 32'd1);
    reset_n = 1'b0;
    req0 = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_enable", 32'(dp_enable), 32'd0);
    check("arst_dones", 32'({done0, done1}), 32'd0);
    check("arst_sum", 32'(sum_out), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    a1 = 8'h0F; b1 = 8'h01; req1 = 1'b1;
    push_exp(1'b1, 8'h0F, 8'h01);
    wait_done();
    req1 = 1'b0;
    tick();

    // Operands sampled only at grant; later changes ignored
    a0 = 8'h80; b0 = 8'h80; req0 = 1'b1;
    push_exp(1'b0, 8'h80, 8'h80);
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      tick();
      a0 = W'($urandom_range(0, 255));
      b0 = W'($urandom_range(0, 255));
    end
    check("op_change_timeout", 32'(got_done), 32'd1);
    req0 = 1'b0;
    repeat (3) tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
